// File: rtl/pipe_pkg.sv
// pipe_pkg: shared ALU opcode encoding, register-index width and operand select values.
package pipe_pkg;
    localparam int REG_IDX_W = 5;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SRL  = 4'd3,
        ALU_SRA  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_XOR  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;
    localparam logic A_SEL_RS1 = 1'b0;
    localparam logic A_SEL_PC  = 1'b1;
    localparam logic B_SEL_RS2 = 1'b0;
    localparam logic B_SEL_IMM = 1'b1;
endpackage

// File: rtl/fwd_mux.sv
// fwd_mux: picks the newest in-flight value for one source register; EX/MEM beats MEM/WB, x0 never forwards.
module fwd_mux
    import pipe_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [REG_IDX_W-1:0] rs_addr,
    input  logic [N-1:0]         rs_data,
    input  logic [REG_IDX_W-1:0] exmem_rd_addr,
    input  logic                 exmem_rd_wren,
    input  logic [N-1:0]         exmem_data,
    input  logic [REG_IDX_W-1:0] memwb_rd_addr,
    input  logic                 memwb_rd_wren,
    input  logic [N-1:0]         memwb_data,
    output logic [N-1:0]         data
);
    logic exmem_hit, memwb_hit;
    assign exmem_hit = exmem_rd_wren && (exmem_rd_addr == rs_addr) && (rs_addr != '0);
    assign memwb_hit = memwb_rd_wren && (memwb_rd_addr == rs_addr) && (rs_addr != '0);
    assign data = exmem_hit ? exmem_data : memwb_hit ? memwb_data : rs_data;
endmodule

// File: rtl/id_ex_reg.sv
// id_ex_reg: ID/EX pipeline register with stall/flush and operand selection.
// Define ID_EX_FWD_EN to build EX/MEM and MEM/WB operand forwarding.
module id_ex_reg
    import pipe_pkg::*;
#(
    parameter int N = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_stall,
    input  logic                 i_flush,
    input  logic                 i_valid,
    input  logic [N-1:0]         i_pc,
    input  logic [N-1:0]         i_rs1_data,
    input  logic [N-1:0]         i_rs2_data,
    input  logic [N-1:0]         i_imm,
    input  logic [REG_IDX_W-1:0] i_rs1_addr,
    input  logic [REG_IDX_W-1:0] i_rs2_addr,
    input  logic [REG_IDX_W-1:0] i_rd_addr,
    input  logic [3:0]           i_alu_op,
    input  logic                 i_a_sel,
    input  logic                 i_b_sel,
    input  logic                 i_rd_wren,
    input  logic [REG_IDX_W-1:0] i_exmem_rd_addr,
    input  logic [REG_IDX_W-1:0] i_memwb_rd_addr,
    input  logic                 i_exmem_rd_wren,
    input  logic                 i_memwb_rd_wren,
    input  logic [N-1:0]         i_exmem_data,
    input  logic [N-1:0]         i_memwb_data,
    output logic [N-1:0]         o_op_a,
    output logic [N-1:0]         o_op_b,
    output logic [N-1:0]         o_rs2_fwd,
    output logic [3:0]           o_alu_op,
    output logic [REG_IDX_W-1:0] o_rd_addr,
    output logic                 o_rd_wren,
    output logic                 o_valid,
    output logic [N-1:0]         o_pc
);
    logic [N-1:0]         pc_q, rs1_q, rs2_q, imm_q, rs1_fwd, rs2_fwd;
    logic [REG_IDX_W-1:0] rs1_addr_q, rs2_addr_q, rd_addr_q;
    alu_op_e              alu_op_q;
    logic                 a_sel_q, b_sel_q, rd_wren_q, valid_q;

    // Flush takes priority over stall and loads an all-zero bubble.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n || i_flush) begin
            pc_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            imm_q      <= '0;
            rs1_addr_q <= '0;
            rs2_addr_q <= '0;
            rd_addr_q  <= '0;
            alu_op_q   <= ALU_ADD;
            a_sel_q    <= A_SEL_RS1;
            b_sel_q    <= B_SEL_RS2;
            rd_wren_q  <= 1'b0;
            valid_q    <= 1'b0;
        end else if (!i_stall) begin
            pc_q       <= i_pc;
            rs1_q      <= i_rs1_data;
            rs2_q      <= i_rs2_data;
            imm_q      <= i_imm;
            rs1_addr_q <= i_rs1_addr;
            rs2_addr_q <= i_rs2_addr;
            rd_addr_q  <= i_rd_addr;
            alu_op_q   <= alu_op_e'(i_alu_op);
            a_sel_q    <= i_a_sel;
            b_sel_q    <= i_b_sel;
            rd_wren_q  <= i_rd_wren && i_valid;
            valid_q    <= i_valid;
        end
    end

`ifdef ID_EX_FWD_EN
    fwd_mux #(.N(N)) u_fwd_rs1 (
        .rs_addr(rs1_addr_q), .rs_data(rs1_q),
        .exmem_rd_addr(i_exmem_rd_addr), .exmem_rd_wren(i_exmem_rd_wren), .exmem_data(i_exmem_data),
        .memwb_rd_addr(i_memwb_rd_addr), .memwb_rd_wren(i_memwb_rd_wren), .memwb_data(i_memwb_data),
        .data(rs1_fwd)
    );
    fwd_mux #(.N(N)) u_fwd_rs2 (
        .rs_addr(rs2_addr_q), .rs_data(rs2_q),
        .exmem_rd_addr(i_exmem_rd_addr), .exmem_rd_wren(i_exmem_rd_wren), .exmem_data(i_exmem_data),
        .memwb_rd_addr(i_memwb_rd_addr), .memwb_rd_wren(i_memwb_rd_wren), .memwb_data(i_memwb_data),
        .data(rs2_fwd)
    );
`else
    // Without forwarding the hazard unit stalls instead, so these inputs are don't-care.
    logic fwd_unused;
    assign fwd_unused = ^{i_exmem_rd_addr, i_memwb_rd_addr, i_exmem_rd_wren, i_memwb_rd_wren,
                          i_exmem_data, i_memwb_data, rs1_addr_q, rs2_addr_q};
    assign rs1_fwd = rs1_q;
    assign rs2_fwd = rs2_q;
`endif

    assign o_op_a    = (a_sel_q == A_SEL_PC) ? pc_q : rs1_fwd;
    assign o_op_b    = (b_sel_q == B_SEL_IMM) ? imm_q : rs2_fwd;
    assign o_rs2_fwd = rs2_fwd;
    assign o_alu_op  = alu_op_q;
    assign o_rd_addr = rd_addr_q;
    assign o_rd_wren = rd_wren_q;
    assign o_valid   = valid_q;
    assign o_pc      = pc_q;
endmodule

// File: tb/tb_id_ex_reg.sv
// tb_id_ex_reg: directed self-checking bench for id_ex_reg against a behavioural model (honours ID_EX_FWD_EN).
module tb_id_ex_reg;
    import pipe_pkg::*;

    logic        i_clk = 0, i_rst_n = 1, i_stall = 0, i_flush = 0, i_valid = 0;
    logic [31:0] i_pc = 0, i_rs1_data = 0, i_rs2_data = 0, i_imm = 0;
    logic [4:0]  i_rs1_addr = 0, i_rs2_addr = 0, i_rd_addr = 0;
    logic [3:0]  i_alu_op = 0;
    logic        i_a_sel = 0, i_b_sel = 0, i_rd_wren = 0;
    logic [4:0]  i_exmem_rd_addr = 0, i_memwb_rd_addr = 0;
    logic        i_exmem_rd_wren = 0, i_memwb_rd_wren = 0;
    logic [31:0] i_exmem_data = 0, i_memwb_data = 0;
    logic [31:0] o_op_a, o_op_b, o_rs2_fwd, o_pc;
    logic [3:0]  o_alu_op;
    logic [4:0]  o_rd_addr;
    logic        o_rd_wren, o_valid;

    int errors = 0, checks = 0;
    bit chk_en = 0;

    id_ex_reg #(.N(32)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_stall(i_stall), .i_flush(i_flush), .i_valid(i_valid),
        .i_pc(i_pc), .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data), .i_imm(i_imm),
        .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr), .i_rd_addr(i_rd_addr),
        .i_alu_op(i_alu_op), .i_a_sel(i_a_sel), .i_b_sel(i_b_sel), .i_rd_wren(i_rd_wren),
        .i_exmem_rd_addr(i_exmem_rd_addr), .i_memwb_rd_addr(i_memwb_rd_addr),
        .i_exmem_rd_wren(i_exmem_rd_wren), .i_memwb_rd_wren(i_memwb_rd_wren),
        .i_exmem_data(i_exmem_data), .i_memwb_data(i_memwb_data),
        .o_op_a(o_op_a), .o_op_b(o_op_b), .o_rs2_fwd(o_rs2_fwd), .o_alu_op(o_alu_op),
        .o_rd_addr(o_rd_addr), .o_rd_wren(o_rd_wren), .o_valid(o_valid), .o_pc(o_pc)
    );

    always #5 i_clk = ~i_clk;

    // Model state: what the ID/EX slot architecturally holds; m_known is 0 after a flush bubble.
    logic        m_valid = 0, m_wren = 0, m_known = 1, m_asel = 0, m_bsel = 0;
    logic [3:0]  m_alu = 0;
    logic [4:0]  m_rs1a = 0, m_rs2a = 0, m_rd = 0;
    logic [31:0] m_pc = 0, m_rs1 = 0, m_rs2 = 0, m_imm = 0;

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            {m_valid, m_wren, m_asel, m_bsel, m_alu, m_rs1a, m_rs2a, m_rd} <= '0;
            {m_pc, m_rs1, m_rs2, m_imm} <= '0;
            m_known <= 1;
        end else if (i_flush) begin
            m_valid <= 0; m_wren <= 0; m_alu <= 4'(ALU_ADD); m_known <= 0;
        end else if (!i_stall) begin
            m_valid <= i_valid; m_wren <= i_valid & i_rd_wren; m_alu <= i_alu_op; m_known <= 1;
            m_asel <= i_a_sel; m_bsel <= i_b_sel; m_rs1a <= i_rs1_addr; m_rs2a <= i_rs2_addr;
            m_rd <= i_rd_addr; m_pc <= i_pc; m_rs1 <= i_rs1_data; m_rs2 <= i_rs2_data; m_imm <= i_imm;
        end
    end

    function automatic logic [31:0] fwd_exp(input logic [4:0] a, input logic [31:0] d);
`ifdef ID_EX_FWD_EN
        if (a != 0 && i_exmem_rd_wren && i_exmem_rd_addr == a) return i_exmem_data;
        if (a != 0 && i_memwb_rd_wren && i_memwb_rd_addr == a) return i_memwb_data;
`endif
        return d;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge i_clk) if (chk_en) begin
        check("m_valid", 32'(o_valid), 32'(m_valid));
        check("m_rd_wren", 32'(o_rd_wren), 32'(m_wren));
        check("m_alu_op", 32'(o_alu_op), 32'(m_alu));
        if (m_known) begin
            check("m_rd_addr", 32'(o_rd_addr), 32'(m_rd));
            check("m_pc", o_pc, m_pc);
            check("m_op_a", o_op_a, m_asel ? m_pc : fwd_exp(m_rs1a, m_rs1));
            check("m_op_b", o_op_b, m_bsel ? m_imm : fwd_exp(m_rs2a, m_rs2));
            check("m_rs2_fwd", o_rs2_fwd, fwd_exp(m_rs2a, m_rs2));
        end
    end

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic instr(input logic [31:0] rs1, input logic [31:0] rs2, input logic [4:0] a1,
                         input logic [4:0] a2, input logic [4:0] rd, input alu_op_e op);
        i_valid = 1; i_rd_wren = 1; i_rs1_data = rs1; i_rs2_data = rs2;
        i_rs1_addr = a1; i_rs2_addr = a2; i_rd_addr = rd; i_alu_op = op;
    endtask

    initial begin
        #2 i_rst_n = 0;
        #1 chk_en = 1;
        check("rst_valid", 32'(o_valid), 0);
        check("rst_rd_wren", 32'(o_rd_wren), 0);
        check("rst_alu_op", 32'(o_alu_op), 32'(ALU_ADD));
        check("rst_op_a", o_op_a, 0);
        check("rst_op_b", o_op_b, 0);
        tick();
        i_rst_n = 1;
        // Basic capture: SRA of 0x80000000 by 4
        instr(32'h8000_0000, 32'd4, 5'd1, 5'd2, 5'd3, ALU_SRA);
        tick();
        check("cap_op_a", o_op_a, 32'h8000_0000);
        check("cap_op_b", o_op_b, 32'd4);
        check("cap_alu_op", 32'(o_alu_op), 32'(ALU_SRA));
        check("cap_valid", 32'(o_valid), 1);
        // Forwarding priority on rs1
        instr(32'h33, 32'h55, 5'd5, 5'd7, 5'd6, ALU_ADD);
        tick();
        i_exmem_rd_addr = 5; i_exmem_rd_wren = 1; i_exmem_data = 32'h11;
        i_memwb_rd_addr = 5; i_memwb_rd_wren = 1; i_memwb_data = 32'h22;
        #1;
`ifdef ID_EX_FWD_EN
        check("fwd_exmem", o_op_a, 32'h11);
`else
        check("nofwd_exmem", o_op_a, 32'h33);
`endif
        i_exmem_rd_wren = 0;
        #1;
`ifdef ID_EX_FWD_EN
        check("fwd_memwb", o_op_a, 32'h22);
`else
        check("nofwd_memwb", o_op_a, 32'h33);
`endif
        i_memwb_rd_addr = 7;
        #1;
`ifdef ID_EX_FWD_EN
        check("fwd_rs2", o_rs2_fwd, 32'h22);
`else
        check("nofwd_rs2", o_rs2_fwd, 32'h55);
`endif
        tick();
        // x0 never forwards; also b_sel=1 picks imm while rs2_fwd stays rs2
        instr(32'h44, 32'h66, 5'd0, 5'd0, 5'd8, ALU_OR);
        i_b_sel = 1; i_imm = 32'hABC;
        i_memwb_rd_wren = 0;
        tick();
        i_exmem_rd_addr = 0; i_exmem_rd_wren = 1; i_exmem_data = 32'hFF;
        #1;
        check("x0_op_a", o_op_a, 32'h44);
        check("bsel_imm", o_op_b, 32'hABC);
        check("bsel_rs2_fwd", o_rs2_fwd, 32'h66);
        i_exmem_rd_wren = 0; i_b_sel = 0;
        // a_sel=1 picks pc
        instr(32'h1234, 32'h9, 5'd10, 5'd11, 5'd9, ALU_XOR);
        i_a_sel = 1; i_pc = 32'h400;
        tick();
        check("asel_pc", o_op_a, 32'h400);
        i_a_sel = 0;
        tick();
        // Stall three cycles while inputs churn
        i_stall = 1;
        for (int k = 0; k < 3; k++) begin
            instr(32'hDEAD_0000 + 32'(k), 32'h77, 5'd12, 5'd13, 5'd14, ALU_SUB);
            i_valid = k[0];
            tick();
            check("stall_op_a", o_op_a, 32'h1234);
            check("stall_alu_op", 32'(o_alu_op), 32'(ALU_XOR));
            check("stall_rd_addr", 32'(o_rd_addr), 9);
        end
        // Flush beats stall
        i_flush = 1;
        tick();
        check("flush_valid", 32'(o_valid), 0);
        check("flush_rd_wren", 32'(o_rd_wren), 0);
        check("flush_alu_op", 32'(o_alu_op), 32'(ALU_ADD));
        i_flush = 0; i_stall = 0;
        // Captured bubble suppresses rd write enable
        instr(32'h5, 32'h6, 5'd1, 5'd2, 5'd3, ALU_AND);
        i_valid = 0;
        tick();
        check("bubble_rd_wren", 32'(o_rd_wren), 0);
        check("bubble_valid", 32'(o_valid), 0);
        // Asynchronous reset mid-cycle overrides stall and flush
        instr(32'h99, 32'h98, 5'd1, 5'd2, 5'd3, ALU_SLT);
        tick();
        check("pre_rst_valid", 32'(o_valid), 1);
        i_stall = 1;
        #1 i_rst_n = 0;
        #1;
        check("async_rst_valid", 32'(o_valid), 0);
        check("async_rst_rd_wren", 32'(o_rd_wren), 0);
        i_flush = 1;
        tick();
        check("rst_hold_valid", 32'(o_valid), 0);
        #2 i_rst_n = 1;
        i_stall = 0; i_flush = 0;
        tick();
        check("post_rst_valid", 32'(o_valid), 1);
        check("post_rst_op_a", o_op_a, 32'h99);
        tick();
        tick();
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end
endmodule
